// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the fetched word plus its PC+4 into the IF/ID pipeline register.
// Handles EX redirects (flush), hazard-unit stalls and a HALT opcode that freezes fetch.
module if_stage #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [31:0]          NOP_INSTR   = 32'h0000_0000,
  parameter logic [5:0]           HALT_OPCODE = 6'b111111,
  parameter int unsigned          CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [31:0]          ifid_instr,
  output logic [PC_WIDTH-1:0]  ifid_pc4,
  output logic                 ifid_valid,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [PC_WIDTH-1:0]  pc4_q, pc4_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [PC_WIDTH-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  // Next-state selection; priority is redirect > stall > halted > normal fetch.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (branch_taken) begin
      // Any HALT already fetched is on the wrong path, so fetch is released too.
      pc_d     = {branch_target[PC_WIDTH-1:2], 2'b00};
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else if (stall) begin
      // Hold everything.
    end else if (halted_q) begin
      // HALT word has already gone downstream; feed bubbles from here on.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CNT_WIDTH'(1);
      if (imem_rdata[31:26] == HALT_OPCODE) begin
        halted_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Address comes straight from the PC register, so it only moves on edges or reset.
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of per-edge vectors plus a hand-written
// asynchronous-reset-during-stall sequence.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int n_checks;
  int n_errors;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h00E9_1020;
      32'h0000_0004: mem_word = 32'h8CE5_0006;
      32'h0000_0008: mem_word = 32'hACA2_0004;
      32'h0000_000C: mem_word = 32'hFC00_0000;
      32'h0000_0020: mem_word = 32'h1111_1111;
      32'h0000_0040: mem_word = 32'h2222_2222;
      32'hFFFF_FFFC: mem_word = 32'h3333_3333;
      default:       mem_word = 32'h2000_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        chk_pc4;
    logic        e_valid;
    logic        e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".pc"},        pc,                 v.e_pc);
    check({tag, ".imem_addr"}, imem_addr,          v.e_pc);
    check({tag, ".instr"},     ifid_instr,         v.e_instr);
    if (v.chk_pc4) check({tag, ".pc4"}, ifid_pc4,  v.e_pc4);
    check({tag, ".valid"},     {31'b0, ifid_valid}, {31'b0, v.e_valid});
    check({tag, ".halted"},    {31'b0, halted},     {31'b0, v.e_halted});
    check({tag, ".count"},     {16'b0, fetch_count}, {16'b0, v.e_cnt});
  endtask

  initial begin
    vec_t rv;
    n_checks = 0;
    n_errors = 0;

    //                stl   br    tgt            pc             instr          pc4           chk   v     h     cnt
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h4,        32'h00E91020, 32'h4,        1'b1, 1'b1, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h8,        32'h8CE50006, 32'h8,        1'b1, 1'b1, 1'b0, 16'd2});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h8,        32'h8CE50006, 32'h8,        1'b1, 1'b1, 1'b0, 16'd2});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h8,        32'h8CE50006, 32'h8,        1'b1, 1'b1, 1'b0, 16'd2});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'hC,        32'hACA20004, 32'hC,        1'b1, 1'b1, 1'b0, 16'd3});
    // Redirect with coincident stall, while a HALT word sits at pc=12.
    vecs.push_back('{1'b1, 1'b1, 32'h23,       32'h20,       32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 16'd3});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h24,       32'h11111111, 32'h24,       1'b1, 1'b1, 1'b0, 16'd4});
    vecs.push_back('{1'b0, 1'b1, 32'hC,        32'hC,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 16'd4});
    // HALT fetch and subsequent bubbles.
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h10,       32'hFC000000, 32'h10,       1'b1, 1'b1, 1'b1, 16'd5});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h10,       32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 16'd5});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h10,       32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 16'd5});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h10,       32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 16'd5});
    vecs.push_back('{1'b0, 1'b1, 32'h40,       32'h40,       32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 16'd5});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h44,       32'h22222222, 32'h44,       1'b1, 1'b1, 1'b0, 16'd6});
    // PC wrap.
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 16'd6});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        32'h33333333, 32'h0,        1'b1, 1'b1, 1'b0, 16'd7});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h4,        32'h00E91020, 32'h4,        1'b1, 1'b1, 1'b0, 16'd8});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h8,        32'h8CE50006, 32'h8,        1'b1, 1'b1, 1'b0, 16'd9});

    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rv = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0};
    check_all("reset", rv);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall         = vecs[i].stl;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset asserted mid-cycle during a stall at a non-zero PC.
    stall        = 1'b1;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset.pc", pc, 32'h8);
    #2;
    reset = 1'b1;
    #1;
    rv = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0};
    check_all("async_reset", rv);
    #2;
    reset = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    rv = '{1'b0, 1'b0, 32'h0, 32'h4, 32'h00E91020, 32'h4, 1'b1, 1'b1, 1'b0, 16'd1};
    check_all("post_reset", rv);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the decode stage.
- Owns the PC register and drives the instruction-memory address. Captures the returned word into the IF/ID pipeline register.
- Handles load-use stalls from the hazard unit, taken-branch redirects/flushes from EX, and a HALT opcode that freezes fetch so testbenches can end deterministically.

Parameters:
- PC_WIDTH, 32, width of PC, memory address and PC+4 path.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word injected into IF/ID on flush, halt or reset.
- HALT_OPCODE, 6'b111111, instr[31:26] value that halts fetch.
- CNT_WIDTH, 16, width of the fetch counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit hold: freeze PC and IF/ID.
- branch_taken  input  1  EX-stage redirect request.
- branch_target  input  PC_WIDTH  redirect address. Bits [1:0] are ignored (forced 0).
- imem_addr  output  PC_WIDTH  equals pc (combinational).
- imem_rdata  input  32  instruction word at imem_addr, same-cycle combinational read.
- pc  output  PC_WIDTH  current fetch PC.
- ifid_instr  output  32  registered instruction to decode.
- ifid_pc4  output  PC_WIDTH  registered PC+4 of that instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  HALT captured; fetch frozen.
- fetch_count  output  CNT_WIDTH  number of instructions captured with valid=1.

Behaviour:
- Reset (async, immediate on assertion, held while high):
  - pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, halted=0, fetch_count=0.
  - First fetch is at RESET_PC on the first rising edge after deassertion.
- Per rising edge, priority is branch_taken > stall > halted > normal.
- Redirect (branch_taken=1):
  - pc <= {branch_target[PC_WIDTH-1:2],2'b00}.
  - ifid_instr <= NOP_INSTR, ifid_valid <= 0 (flushes the wrong-path word).
  - halted <= 0, because any HALT already fetched is younger than the branch.
  - A coincident stall is overridden.
- Stall (stall=1, no redirect):
  - pc, ifid_instr, ifid_pc4, ifid_valid, halted and fetch_count all hold.
  - Multi-cycle stalls hold indefinitely.
- Halted (halted=1, no redirect, no stall):
  - pc holds.
  - ifid_instr <= NOP_INSTR, ifid_valid <= 0; the HALT word itself propagates once, then bubbles follow.
  - fetch_count holds.
- Normal:
  - pc <= pc+4, modulo 2^PC_WIDTH (all-ones-aligned PC wraps to 0).
  - ifid_instr <= imem_rdata, ifid_pc4 <= pc+4, ifid_valid <= 1.
  - fetch_count <= fetch_count+1, wrapping at 2^CNT_WIDTH.
  - If imem_rdata[31:26]==HALT_OPCODE, halted <= 1 in the same edge and pc still advances by 4 that edge.
- Latency: the word at address A appears on ifid_instr one edge after pc==A with no stall/redirect.
- No combinational path from stall/branch_taken to imem_addr; imem_addr changes only on clock edges or reset.
- Reset asserted mid-operation (including during stall or halt) overrides everything asynchronously.

Test Plan:
- Reset then 3 free-running cycles, mem[0]=0x00E91020, mem[4]=0x8CE50006, mem[8]=0xACA20004 -> pc 0,4,8,12. IF/ID shows those words with pc4 4,8,12, valid=1, fetch_count=3.
- stall=1 for 2 cycles at pc=8 -> pc stays 8, IF/ID holds mem[4]/pc4=8, fetch_count unchanged. Release -> mem[8] captured next edge.
- branch_taken=1 with branch_target=0x0000_0023 at pc=12, stall=1 simultaneously -> pc=0x20, ifid_instr=0, valid=0. Next edge captures mem[0x20], valid=1.
- mem[12]=0xFC000000 (HALT) -> halted=1 with IF/ID=HALT, pc=16. Following edges: pc=16, IF/ID=NOP, valid=0, fetch_count frozen. branch_taken to 0x40 -> halted=0, fetch resumes at 0x40.
- Preload pc near wrap by redirect to 0xFFFF_FFFC, free-run -> captures mem[0xFFFF_FFFC] with pc4=0, then pc=0.
- Assert reset mid-stall at non-zero PC, asynchronously between edges -> all outputs return to reset values before the next clk edge.
